lsm_sequencer: RTL and testbench

//  Multi-cycle sequencer for LDM/STM. Sits directly upstream of the register bank.

---
 rtl/lsm_pkg.sv | 72 +++++++
 rtl/lsm_priority_enc.sv | 21 ++
 rtl/lsm_sequencer.sv | 130 +++++++++++++
 tb/tb_lsm_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsm_pkg.sv
// Shared types and helpers for the LDM/STM sequencer: state encoding,
// IR field positions, register-list popcount and start-address decode.
package lsm_pkg;

  localparam int DATA_W     = 32;
  localparam int NREG       = 16;
  localparam int WORD_BYTES = 4;

  localparam int IR_P      = 24;
  localparam int IR_U      = 23;
  localparam int IR_W      = 21;
  localparam int IR_L      = 20;
  localparam int IR_RN_LSB = 16;

  localparam logic [DATA_W-1:0] WORD_STEP = DATA_W'(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } lsm_state_t;

  // Encoding is {P,U} so the mode can be cast straight from the IR bits.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } lsm_mode_t;

  function automatic logic [4:0] popcount16(input logic [NREG-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {4'b0, v[i]};
    end
    return c;
  endfunction

  function automatic lsm_mode_t decode_mode(input logic p, input logic u);
    return lsm_mode_t'({p, u});
  endfunction

  function automatic logic [DATA_W-1:0] span_bytes(input logic [4:0] n);
    return {{(DATA_W-7){1'b0}}, n, 2'b00};
  endfunction

  // Lowest address touched by the transfer; beats then walk upwards.
  function automatic logic [DATA_W-1:0] start_addr(input lsm_mode_t mode,
                                                   input logic [DATA_W-1:0] base,
                                                   input logic [4:0] n);
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] addr;
    aligned = {base[DATA_W-1:2], 2'b00};
    case (mode)
      MODE_IA: addr = aligned;
      MODE_IB: addr = aligned + WORD_STEP;
      MODE_DA: addr = aligned - span_bytes(n) + WORD_STEP;
      MODE_DB: addr = aligned - span_bytes(n);
      default: addr = aligned;
    endcase
    return addr;
  endfunction

  function automatic logic [DATA_W-1:0] wb_value(input logic u,
                                                 input logic [DATA_W-1:0] base,
                                                 input logic [4:0] n);
    return u ? (base + span_bytes(n)) : (base - span_bytes(n));
  endfunction

endpackage

// File: rtl/lsm_priority_enc.sv
// Lowest-set-bit encoder for the 16-entry register list.
module lsm_priority_enc
  import lsm_pkg::*;
(
  input  logic [NREG-1:0] list,
  output logic [3:0]      idx,
  output logic            valid
);

  // Scan from the top so the lowest set bit is the last to write idx.
  always_comb begin
    idx   = '0;
    valid = |list;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (list[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM multi-cycle sequencer: walks the register list lowest-first,
// issues one memory beat per register, then optional base writeback.
module lsm_sequencer
  import lsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              START,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] BASE,
  input  logic              MEM_READY,
  output logic [3:0]        LSM_RD,
  output logic [DATA_W-1:0] ADDR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic              LATCH_LSM,
  output logic              WB_EN,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              BUSY,
  output logic              DONE
);

  lsm_state_t        state_q, state_d;
  logic [NREG-1:0]   list_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [3:0]        rn_q;
  logic              load_q;
  logic              wb_pend_q;

  logic [NREG-1:0]   ir_list;
  logic [3:0]        ir_rn;
  logic [4:0]        ir_count;
  logic [NREG-1:0]   list_rest;
  logic [3:0]        low_idx;
  logic              low_valid;
  logic              unused_ir;

  assign ir_list   = IR[NREG-1:0];
  assign ir_rn     = IR[IR_RN_LSB +: 4];
  assign ir_count  = popcount16(ir_list);
  assign list_rest = list_q & (list_q - 16'd1);
  assign unused_ir = ^{IR[31:25], IR[22]};

  lsm_priority_enc u_prio (
    .list  (list_q),
    .idx   (low_idx),
    .valid (low_valid)
  );

  // Capture the whole transfer on START, then retire one list bit per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      list_q    <= '0;
      addr_q    <= '0;
      wb_data_q <= '0;
      rn_q      <= '0;
      load_q    <= 1'b0;
      wb_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (START) begin
            list_q    <= ir_list;
            addr_q    <= start_addr(decode_mode(IR[IR_P], IR[IR_U]), BASE, ir_count);
            wb_data_q <= wb_value(IR[IR_U], BASE, ir_count);
            rn_q      <= ir_rn;
            load_q    <= IR[IR_L];
            wb_pend_q <= IR[IR_W] & ~(IR[IR_L] & ir_list[ir_rn]) & (|ir_list);
          end
        end
        XFER: begin
          if (MEM_READY) begin
            list_q <= list_rest;
            addr_q <= addr_q + WORD_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state only, so reset forces them all low immediately.
  always_comb begin
    state_d   = state_q;
    LSM_RD    = '0;
    ADDR      = '0;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    LATCH_LSM = 1'b0;
    WB_EN     = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    WB_DATA   = wb_data_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = (ir_list == '0) ? FIN : XFER;
        end
      end
      XFER: begin
        BUSY    = 1'b1;
        MEM_REQ = low_valid;
        MEM_WE  = ~load_q;
        LSM_RD  = low_idx;
        ADDR    = addr_q;
        if (MEM_READY) begin
          LATCH_LSM = load_q;
          if (list_rest == '0) begin
            state_d = wb_pend_q ? WB : FIN;
          end
        end
      end
      WB: begin
        BUSY    = 1'b1;
        WB_EN   = 1'b1;
        LSM_RD  = rn_q;
        state_d = FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer: table of LDM/STM vectors plus
// hand sequences for memory stalls, START while busy and mid-transfer reset.
module tb_lsm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        START;
  logic [31:0] IR;
  logic [31:0] BASE;
  logic        MEM_READY;
  logic [3:0]  LSM_RD;
  logic [31:0] ADDR;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        LATCH_LSM;
  logic        WB_EN;
  logic [31:0] WB_DATA;
  logic        BUSY;
  logic        DONE;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] base;
    logic [31:0] first_addr;
    logic        exp_wb;
    logic [31:0] wb_data;
    int          done_cycle;
  } vec_t;

  vec_t vecs[8];

  lsm_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .START     (START),
    .IR        (IR),
    .BASE      (BASE),
    .MEM_READY (MEM_READY),
    .LSM_RD    (LSM_RD),
    .ADDR      (ADDR),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .LATCH_LSM (LATCH_LSM),
    .WB_EN     (WB_EN),
    .WB_DATA   (WB_DATA),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one transfer from START to DONE; cycle 1 is the START cycle.
  task automatic applyStimulus(input vec_t v, input int stall, input logic poke);
    logic [15:0] list;
    logic [31:0] exp_addr;
    logic [3:0]  exp_idx;
    logic        load;
    int          exp_beats;
    int          beats;
    int          wb_seen;
    int          cycle;
    int          stall_left;
    logic        done;
    list       = v.ir[15:0];
    load       = v.ir[20];
    exp_addr   = v.first_addr;
    exp_beats  = 0;
    for (int i = 0; i < 16; i++) exp_beats += int'(list[i]);
    beats      = 0;
    wb_seen    = 0;
    cycle      = 1;
    stall_left = stall;
    done       = 1'b0;
    @(posedge clk);
    #1;
    START     = 1'b1;
    IR        = v.ir;
    BASE      = v.base;
    MEM_READY = 1'b1;
    while (!done && cycle < 60) begin
      @(posedge clk);
      #1;
      cycle++;
      START = poke && (cycle == 2);
      if (poke) IR = 32'h0080_0001;
      MEM_READY = (beats == 0 && stall_left > 0) ? 1'b0 : 1'b1;
      #1;
      if (MEM_REQ) begin
        exp_idx = 4'd0;
        for (int i = 15; i >= 0; i--) if (list[i]) exp_idx = 4'(i);
        checkOutput("beat_addr", ADDR, exp_addr);
        checkOutput("beat_rd", {28'b0, LSM_RD}, {28'b0, exp_idx});
        checkOutput("beat_we", {31'b0, MEM_WE}, {31'b0, ~load});
        checkOutput("beat_busy", {31'b0, BUSY}, 32'd1);
        if (MEM_READY) begin
          checkOutput("beat_latch", {31'b0, LATCH_LSM}, {31'b0, load});
          list     = list & (list - 16'd1);
          exp_addr = exp_addr + 32'd4;
          beats++;
        end else begin
          checkOutput("stall_latch", {31'b0, LATCH_LSM}, 32'd0);
          stall_left--;
        end
      end else begin
        checkOutput("latch_idle", {31'b0, LATCH_LSM}, 32'd0);
      end
      if (WB_EN) begin
        wb_seen++;
        checkOutput("wb_data", WB_DATA, v.wb_data);
        checkOutput("wb_rd", {28'b0, LSM_RD}, {28'b0, v.ir[19:16]});
      end
      if (DONE) begin
        done = 1'b1;
        checkOutput("done_busy", {31'b0, BUSY}, 32'd0);
      end
    end
    START = 1'b0;
    checkOutput("done_cycle", cycle, v.done_cycle);
    checkOutput("beat_count", beats, exp_beats);
    checkOutput("wb_count", wb_seen, {31'b0, v.exp_wb});
    @(posedge clk);
    #2;
    checkOutput("post_idle", {29'b0, DONE, BUSY, MEM_REQ}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    START     = 1'b0;
    IR        = '0;
    BASE      = '0;
    MEM_READY = 1'b0;

    // STMIA R0,{R1,R3} with S bit set (ignored)
    vecs[0] = '{32'h00C0_000A, 32'h0000_1000, 32'h0000_1000, 1'b0, 32'h0, 4};
    // LDMDB R2!,{R0,R4,R15}
    vecs[1] = '{32'h0132_8011, 32'h0000_2000, 32'h0000_1FF4, 1'b1, 32'h0000_1FF4, 6};
    // LDMIB R5!,{R5,R6}: writeback suppressed
    vecs[2] = '{32'h01B5_0060, 32'h0000_0100, 32'h0000_0104, 1'b0, 32'h0, 4};
    // STMDA R3!,{R2}
    vecs[3] = '{32'h0023_0004, 32'h0000_0040, 32'h0000_0040, 1'b1, 32'h0000_003C, 4};
    // STMIB R1!,{R1}: store keeps writeback
    vecs[4] = '{32'h01A1_0002, 32'h0000_0200, 32'h0000_0204, 1'b1, 32'h0000_0204, 4};
    // STMIA R4!,{R0,R1} wrapping past 2^32
    vecs[5] = '{32'h00A4_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h0000_0004, 5};
    // LDMDB R7,{R1} with unaligned base
    vecs[6] = '{32'h0117_0002, 32'h0000_1003, 32'h0000_0FFC, 1'b0, 32'h0, 3};
    // STMIA R0!,{} empty list: no beats, no writeback
    vecs[7] = '{32'h00A0_0000, 32'h0000_0800, 32'h0, 1'b0, 32'h0, 2};

    #1;
    checkOutput("reset_addr", ADDR, 32'h0);
    checkOutput("reset_wbdata", WB_DATA, 32'h0);
    checkOutput("reset_ctrl", {22'b0, LSM_RD, MEM_REQ, MEM_WE, LATCH_LSM, WB_EN, BUSY, DONE}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k], 0, 1'b0);
    end

    // Memory holds off the first beat for three cycles.
    applyStimulus('{32'h0090_0006, 32'h0000_3000, 32'h0000_3000, 1'b0, 32'h0, 7}, 3, 1'b0);

    // A second START while busy must not restart or queue anything.
    applyStimulus(vecs[0], 0, 1'b1);

    // Reset in the middle of LDMIA R0!,{R1,R2,R3}.
    @(posedge clk);
    #1;
    START     = 1'b1;
    IR        = 32'h00B0_000E;
    BASE      = 32'h0000_0500;
    MEM_READY = 1'b1;
    @(posedge clk);
    #1;
    START = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_req", {31'b0, MEM_REQ}, 32'd1);
    checkOutput("mid_addr", ADDR, 32'h0000_0504);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_addr", ADDR, 32'h0);
    checkOutput("abort_wbdata", WB_DATA, 32'h0);
    checkOutput("abort_ctrl", {22'b0, LSM_RD, MEM_REQ, MEM_WE, LATCH_LSM, WB_EN, BUSY, DONE}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      checkOutput("abort_hold", {26'b0, MEM_REQ, LATCH_LSM, WB_EN, BUSY, DONE, 1'b0}, 32'h0);
    end
    rst_n = 1'b1;
    applyStimulus(vecs[1], 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
